// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU. It takes the 4-bit Operation code from the ALU
// controller and the two operands from the ID/EX register.
// - Logic, arithmetic and compare ops finish in one cycle.
// - Shifts run on an iterative shifter that moves one bit per cycle.
// - The result goes to EX/MEM through a registered valid/ready output stage.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   flush      synchronous pipeline flush; it has priority over everything
//              except reset
//   in_valid   Operation/SrcA/SrcB are valid
//   in_ready   the unit accepts an operation this cycle
//   Operation  ALU op code
//   SrcA       operand A
//   SrcB       operand B; a shift uses SrcB[SHAMT_W-1:0] as its amount
//   out_valid  ALUResult/Zero hold a result that has not been consumed
//   out_ready  the downstream stage consumes the result
//   ALUResult  result
//   Zero       set when ALUResult == 0; registered with ALUResult
//   busy       an iterative shift is in progress
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter  int DATA_W  = 32,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero,
    output logic              busy
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_BEQ = 4'b1001;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   acc_reg, acc_next;
    logic [SHAMT_W-1:0]  cnt_reg, cnt_next;
    logic [3:0]          op_reg, op_next;
    logic                out_valid_reg, out_valid_next;
    logic [DATA_W-1:0]   result_reg, result_next;
    logic                zero_reg, zero_next;

    logic [SHAMT_W-1:0]  shamt;
    logic                is_shift;
    logic                pop;
    logic [DATA_W-1:0]   comb_result;
    logic [DATA_W-1:0]   acc_shifted;

    // Single-cycle datapath. A shift reaches this path only when its amount
    // is zero, and a zero-amount shift returns SrcA unchanged.
    function automatic logic [DATA_W-1:0] alu_comb(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_AND: r = a & b;
            OP_SUB: r = a - b;
            OP_ADD: r = a + b;
            OP_XOR: r = a ^ b;
            OP_OR:  r = a | b;
            OP_SLT: r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_BEQ: r = {{(DATA_W-1){1'b0}}, (a == b)};
            OP_SLL, OP_SRL, OP_SRA: r = a;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One step of the iterative shifter.
    function automatic logic [DATA_W-1:0] shift_step(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] v
    );
        logic [DATA_W-1:0] r;
        r = v;
        case (op)
            OP_SLL: r = {v[DATA_W-2:0], 1'b0};
            OP_SRL: r = {1'b0, v[DATA_W-1:1]};
            OP_SRA: r = {v[DATA_W-1], v[DATA_W-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign shamt       = SrcB[SHAMT_W-1:0];
    assign is_shift    = (Operation == OP_SLL) || (Operation == OP_SRL) ||
                         (Operation == OP_SRA);
    assign pop         = out_valid_reg && out_ready;
    assign comb_result = alu_comb(Operation, SrcA, SrcB);
    assign acc_shifted = shift_step(op_reg, acc_reg);

    // Next-state, datapath and handshake logic.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        op_next        = op_reg;
        out_valid_next = out_valid_reg;
        result_next    = result_reg;
        zero_next      = zero_reg;
        in_ready       = 1'b0;

        if (flush) begin
            // Drop any operation in flight. ALUResult/Zero keep stale
            // contents because out_valid marks them as meaningless.
            state_next     = IDLE;
            out_valid_next = 1'b0;
            cnt_next       = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Accept a new op when the output slot is empty or is
                    // drained on this same edge.
                    in_ready = !out_valid_reg || out_ready;
                    if (pop) begin
                        out_valid_next = 1'b0;
                    end
                    if (in_valid && in_ready) begin
                        if (is_shift && (shamt != '0)) begin
                            acc_next   = SrcA;
                            cnt_next   = shamt;
                            op_next    = Operation;
                            state_next = SHIFT;
                        end else begin
                            result_next    = comb_result;
                            zero_next      = (comb_result == '0);
                            out_valid_next = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (pop) begin
                        out_valid_next = 1'b0;
                    end
                    acc_next = acc_shifted;
                    cnt_next = cnt_reg - SHAMT_W'(1);
                    // The last step writes the shifted value straight into
                    // the output register, so the result costs no extra
                    // cycle.
                    if (cnt_reg == SHAMT_W'(1)) begin
                        result_next    = acc_shifted;
                        zero_next      = (acc_shifted == '0);
                        out_valid_next = 1'b1;
                        state_next     = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            op_reg        <= '0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            op_reg        <= op_next;
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign ALUResult = result_reg;
    assign Zero      = zero_reg;
    assign busy      = (state_reg == SHIFT);

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_BEQ = 4'b1001;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Operation = '0; SrcA = '0; SrcB = '0;
        #12;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0) begin
            $display("FAIL reset_state: got ov=%b busy=%b res=%h z=%b, expected 0 0 00000000 0",
                     out_valid, busy, ALUResult, Zero);
            errors++;
        end
        #4 reset_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", in_ready); errors++;
        end
        $display("reset: ov=%b busy=%b res=%h in_ready=%b", out_valid, busy, ALUResult, in_ready);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            $display("FAIL add_wrap: got ov=%b res=%h z=%b expected 1 00000000 1", out_valid, ALUResult, Zero);
            errors++;
        end
        $display("ADD ffffffff+1 -> %h z=%b", ALUResult, Zero);
        drive(OP_SUB, 32'd5, 32'd7);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL b2b_in_ready: got %b expected 1", in_ready); errors++;
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || ALUResult !== 32'hFFFF_FFFE || Zero !== 1'b0) begin
            $display("FAIL sub_b2b: got ov=%b res=%h z=%b expected 1 fffffffe 0", out_valid, ALUResult, Zero);
            errors++;
        end
        $display("SUB 5-7 -> %h z=%b", ALUResult, Zero);
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL pop_drain: got ov=%b expected 0", out_valid); errors++;
        end
    endtask

    task automatic test_shift();
        out_ready = 1'b1;
        drive(OP_SRA, 32'h8000_0000, 32'd4);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                $display("FAIL sra_busy[%0d]: got busy=%b in_ready=%b ov=%b expected 1 0 0",
                         i, busy, in_ready, out_valid);
                errors++;
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b1 || ALUResult !== 32'hF800_0000 || busy !== 1'b0 || Zero !== 1'b0) begin
            $display("FAIL sra_result: got ov=%b res=%h busy=%b z=%b expected 1 f8000000 0 0",
                     out_valid, ALUResult, busy, Zero);
            errors++;
        end
        $display("SRA 80000000>>>4 -> %h", ALUResult);
        drive(OP_SLL, 32'h1234, 32'd0);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || ALUResult !== 32'h1234 || busy !== 1'b0) begin
            $display("FAIL sll_zero: got ov=%b res=%h busy=%b expected 1 00001234 0", out_valid, ALUResult, busy);
            errors++;
        end
        $display("SLL 1234<<0 -> %h", ALUResult);
        tick();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        drive(OP_SUB, 32'd5, 32'd7);
        tick();
        drive(OP_OR, 32'h0000_00F0, 32'h0000_0F00);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || ALUResult !== 32'hFFFF_FFFE || in_ready !== 1'b0) begin
                $display("FAIL hold[%0d]: got ov=%b res=%h in_ready=%b expected 1 fffffffe 0",
                         i, out_valid, ALUResult, in_ready);
                errors++;
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL pop_accept_ready: got %b expected 1", in_ready); errors++;
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || ALUResult !== 32'h0000_0FF0) begin
            $display("FAIL or_after_hold: got ov=%b res=%h expected 1 00000ff0", out_valid, ALUResult);
            errors++;
        end
        $display("hold released, OR -> %h", ALUResult);
        tick();
    endtask

    task automatic test_compare();
        logic [3:0]  ops  [5] = '{OP_SLT, OP_BEQ, OP_BEQ, 4'b1100, OP_AND};
        logic [31:0] as   [5] = '{32'hFFFF_FFFF, 32'd7, 32'd7, 32'd5, 32'hFF00_FF00};
        logic [31:0] bs   [5] = '{32'd1, 32'd7, 32'd8, 32'd5, 32'h0FF0_0FF0};
        logic [31:0] exps [5] = '{32'd1, 32'd1, 32'd0, 32'd0, 32'h0F00_0F00};
        logic        expz [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], as[i], bs[i]);
            tick();
            vectors++;
            if (out_valid !== 1'b1 || ALUResult !== exps[i] || Zero !== expz[i]) begin
                $display("FAIL compare[%0d]: got ov=%b res=%h z=%b expected 1 %h %b",
                         i, out_valid, ALUResult, Zero, exps[i], expz[i]);
                errors++;
            end
            $display("op %b a=%h b=%h -> %h z=%b", ops[i], as[i], bs[i], ALUResult, Zero);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 1'b1;
        drive(OP_SRL, 32'hFFFF_FFFF, 32'd31);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL flush_cycle: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
            errors++;
        end
        tick();
        flush = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL flush_idle: got busy=%b ov=%b in_ready=%b expected 0 0 1", busy, out_valid, in_ready);
            errors++;
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen); errors++;
        end
        drive(OP_ADD, 32'd2, 32'd3);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || ALUResult !== 32'd5 || Zero !== 1'b0) begin
            $display("FAIL add_after_flush: got ov=%b res=%h z=%b expected 1 00000005 0", out_valid, ALUResult, Zero);
            errors++;
        end
        $display("flush mid-SRL, then ADD 2+3 -> %h", ALUResult);
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        drive(OP_SLL, 32'd1, 32'd20);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0) begin
            $display("FAIL async_reset: got ov=%b busy=%b res=%h z=%b expected 0 0 00000000 0",
                     out_valid, busy, ALUResult, Zero);
            errors++;
        end
        #2 reset_n = 1'b1;
        tick();
        drive(OP_XOR, 32'h0000_F0F0, 32'h0000_FFFF);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL post_reset_ready: got %b expected 1", in_ready); errors++;
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || ALUResult !== 32'h0000_0F0F || Zero !== 1'b0) begin
            $display("FAIL xor_after_reset: got ov=%b res=%h z=%b expected 1 00000f0f 0", out_valid, ALUResult, Zero);
            errors++;
        end
        $display("async reset mid-SLL, then XOR -> %h", ALUResult);
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shift();
        test_hold();
        test_compare();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller, together with the two operands from the ID/EX register. Logic and arithmetic ops complete in one cycle. Shifts run on an iterative 1-bit-per-cycle shifter to save area. The result is delivered to EX/MEM through a valid/ready output register.

Parameters:
DATA_W, 32, operand/result width.
SHAMT_W, $clog2(DATA_W), shift-amount width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush (branch mispredict/trap)
in_valid  input  1  operation/operands valid
in_ready  output  1  unit can accept an operation this cycle
Operation  input  4  ALU op code from ALU controller
SrcA  input  DATA_W  operand A
SrcB  input  DATA_W  operand B (shift amount = SrcB[SHAMT_W-1:0])
out_valid  output  1  ALUResult/Zero valid
out_ready  input  1  downstream consumes result
ALUResult  output  DATA_W  result
Zero  output  1  ALUResult == 0
busy  output  1  iterative shift in progress

Behaviour:
- Interface: one clock, clk; reset_n is asynchronous and active-low.
- Reset (reset_n low, async): state=IDLE, out_valid=0, ALUResult=0, Zero=0, busy=0, shift counter=0. Reset mid-shift discards the operation.
- Op codes:
  - 0000 AND; 0001 SUB (mod 2^DATA_W); 0010 ADD (mod 2^DATA_W); 0110 XOR; 0111 OR.
  - 1000 SLT: signed compare, result 1/0 zero-extended.
  - 1001 BEQ compare: result 1 if SrcA==SrcB, else 0.
  - 0011 SLL; 0100 SRL; 0101 SRA (sign bit replicated each step).
  - 1010–1111: result 0, single-cycle.
- Zero = (ALUResult==0), registered with ALUResult.
- FSM states:
  - IDLE: in_ready = !out_valid || out_ready. Accept when in_valid && in_ready.
    - Non-shift op, or shift with shamt==0: ALUResult/Zero written and out_valid=1 on the accept edge (latency 1). Shift with shamt==0 returns SrcA.
    - Shift with shamt>0: load acc=SrcA, cnt=shamt, latch op, go SHIFT. out_valid clears on this edge if popped.
  - SHIFT: busy=1, in_ready=0. Each edge shifts acc by 1 and decrements cnt.
    - Edge with cnt==1: ALUResult=final value, Zero updated, out_valid=1, state→IDLE.
    - Latency from accept edge to out_valid = shamt+1 edges.
- Output hold: while out_valid && !out_ready, ALUResult/Zero/out_valid are held stable. A pop and a new accept on the same edge are legal, giving back-to-back 1 op/cycle for single-cycle ops.
- out_valid falls on an out_ready pop with no new completion that edge.
- flush (sync, highest priority):
  - state→IDLE, out_valid→0, cnt→0.
  - in_ready forced 0 that cycle; no accept.
  - ALUResult/Zero keep their last value (don't-care).
- Simultaneous flush and reset: reset wins.
- in_valid without in_ready: operands are ignored; the upstream stage holds them.
- busy = (state==SHIFT).

Test Plan:
- ADD SrcA=0xFFFFFFFF, SrcB=1, out_ready=1 → one edge later out_valid=1, ALUResult=0x00000000, Zero=1; SUB 5−7 next cycle → 0xFFFFFFFE, Zero=0, back-to-back without bubble.
- SRA SrcA=0x80000000, SrcB=4 → busy=1 and in_ready=0 for 4 cycles; out_valid after 5 edges with ALUResult=0xF8000000. SLL SrcA=0x1234, SrcB=0 → 0x1234 after 1 edge.
- out_ready=0, SUB 5−7 → out_valid held with 0xFFFFFFFE; in_ready=0 and a pending OR is not accepted. out_ready=1 → pop and OR accepted the same edge; OR result 1 edge later.
- SLT SrcA=0xFFFFFFFF, SrcB=1 → 1. BEQ SrcA=SrcB=7 → ALUResult=1, Zero=0. BEQ 7 vs 8 → 0, Zero=1. Op 1100 → 0, Zero=1.
- SRL SrcA=0xFFFFFFFF, SrcB=31; flush at 10th SHIFT cycle → out_valid never rises for this op; next edge in IDLE with in_ready=1; following ADD 2+3 → 5.
- SLL SrcA=1, SrcB=20; reset_n low asynchronously mid-shift → out_valid, busy, ALUResult, Zero go to 0 immediately. After release, XOR 0xF0F0^0xFFFF → 0x0F0F.
